uart_rx: RTL and testbench

//   UART receive path: samples serial line rx, detects the start bit, and recovers

---
 rtl/uart_rx_pkg.sv | 16 +
 rtl/uart_sync2.sv | 23 ++
 rtl/uart_rx.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encodings and
// default frame parameters (also used by the transmit side).
package uart_rx_pkg;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the asynchronous serial line.
// Resets to 1 so an idle-high line never looks like a start bit coming out of reset.
module uart_sync2 (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // shift the raw input through two flops
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, LSB-first data recovery, stop-bit check.
// Optional even-parity bit enabled by defining UART_PARITY_EN; without it
// parity_err_o is tied low and the PARITY state is never entered.
//
//   state  | meaning
//   IDLE   | waiting for line low
//   START  | counting to mid start bit, rejecting glitches
//   DATA   | sampling data bits at mid bit
//   PARITY | sampling the parity bit at mid bit
//   STOP   | sampling stop bit, publishing the word
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic                 s_tick_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 busy_o
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic                 rxs;
    state_e               state_q, state_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
`ifdef UART_PARITY_EN
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
`endif

    uart_sync2 u_sync (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .d_i      (rx_i),
        .q_o      (rxs)
    );

    // state, counters and output registers
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    // next-state logic; every bit-timed state samples at its terminal tick count
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = ferr_q;
`ifdef UART_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // a tick in this cycle is deliberately ignored
                if (!rxs) begin
                    state_d = ST_START;
                    tcnt_d  = '0;
                end
            end
            ST_START: begin
                if (s_tick_i) begin
                    if (tcnt_q == T_HALF) begin
                        tcnt_d = '0;
                        if (!rxs) begin
                            state_d = ST_DATA;
                            bcnt_d  = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (s_tick_i) begin
                    if (tcnt_q == T_FULL) begin
                        tcnt_d  = '0;
                        shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
                        if (bcnt_q == B_LAST) begin
`ifdef UART_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            bcnt_d = bcnt_q + BW'(1);
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (s_tick_i) begin
                    if (tcnt_q == T_FULL) begin
                        tcnt_d  = '0;
                        par_d   = rxs;
                        state_d = ST_STOP;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
`endif
            ST_STOP: begin
                if (s_tick_i) begin
                    if (tcnt_q == T_FULL) begin
                        // leave at mid stop bit so a back-to-back start edge is seen
                        tcnt_d  = '0;
                        data_d  = shreg_q;
                        ferr_d  = ~rxs;
                        valid_d = 1'b1;
`ifdef UART_PARITY_EN
                        perr_d  = ^{shreg_q, par_q};
`endif
                        state_d = ST_IDLE;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rx_data_o   = data_q;
    assign rx_valid_o  = valid_q;
    assign frame_err_o = ferr_q;
    assign busy_o      = (state_q != ST_IDLE);
`ifdef UART_PARITY_EN
    assign parity_err_o = perr_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame table, random frames against a
// frame-level reference model, plus glitch, back-to-back and mid-frame reset sequences.
// Honours UART_PARITY_EN the same way as the design.
module tb_uart_rx;

    localparam int DB       = 8;
    localparam int OS       = 16;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLK  = OS * TICK_DIV;

    logic          clk;
    logic          arst_n;
    logic          s_tick;
    logic          rx;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          parity_err;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    // observations captured by the monitor: {data, frame_err, parity_err}
    logic [DB+1:0] obs_q[$];
    int            consec_cnt = 0;
    int            valid_total = 0;
    logic          prev_valid = 1'b0;

    typedef struct {
        logic [DB-1:0] data;
        logic          stop;
        logic          par;
        int            gap;
        logic [DB-1:0] exp_data;
        logic          exp_ferr;
        logic          exp_perr;
    } vec_t;

    vec_t vecs[$];

    uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk_i        (clk),
        .arst_n_i     (arst_n),
        .s_tick_i     (s_tick),
        .rx_i         (rx),
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .frame_err_o  (frame_err),
        .parity_err_o (parity_err),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (TICK_DIV - 1) begin
                @(negedge clk);
                s_tick = 1'b0;
            end
            @(negedge clk);
            s_tick = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rx_valid) begin
            obs_q.push_back({rx_data, frame_err, parity_err});
            valid_total = valid_total + 1;
            if (prev_valid) consec_cnt = consec_cnt + 1;
        end
        prev_valid = rx_valid;
    end

    // reference model: what a frame must produce, from the frame's own bits
    function automatic logic model_perr(input logic [DB-1:0] d, input logic p);
`ifdef UART_PARITY_EN
        return ^{d, p};
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic p, input int gap);
        drive(1'b0, BIT_CLK);
        for (int i = 0; i < DB; i++) drive(d[i], BIT_CLK);
`ifdef UART_PARITY_EN
        drive(p, BIT_CLK);
`endif
        if (stop) begin
            drive(1'b1, BIT_CLK);
        end else begin
            // low only past the mid-bit sample point, then back to idle
            drive(1'b0, 44);
            drive(1'b1, BIT_CLK - 44);
        end
        if (gap > 0) drive(1'b1, gap);
    endtask

    task automatic expect_obs(input string name, input logic [DB-1:0] d, input logic fe, input logic pe);
        logic [DB+1:0] o;
        int budget;
        budget = 0;
        while (obs_q.size() == 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        checks = checks + 1;
        if (obs_q.size() == 0) begin
            failures = failures + 1;
            $display("FAIL %s_valid actual=none required=one rx_valid", name);
        end else begin
            o = obs_q.pop_front();
            chk({name, "_data"}, 32'(o[DB+1:2]), 32'(d));
            chk({name, "_ferr"}, 32'(o[1]), 32'(fe));
            chk({name, "_perr"}, 32'(o[0]), 32'(pe));
        end
    endtask

    task automatic push_vec(input logic [DB-1:0] d, input logic st, input logic p, input int gap,
                            input logic [DB-1:0] ed, input logic ef);
        vec_t v;
        v.data = d; v.stop = st; v.par = p; v.gap = gap;
        v.exp_data = ed; v.exp_ferr = ef; v.exp_perr = model_perr(d, p);
        vecs.push_back(v);
    endtask

    initial begin
        logic [DB-1:0] held;
        logic [DB-1:0] rd;
        logic          rs;
        logic          rp;
        int            rg;

        arst_n = 1'b0;
        rx     = 1'b1;
        repeat (5) @(negedge clk);

        chk("reset_data",  32'(rx_data),    32'h0);
        chk("reset_valid", 32'(rx_valid),   32'h0);
        chk("reset_ferr",  32'(frame_err),  32'h0);
        chk("reset_perr",  32'(parity_err), 32'h0);
        chk("reset_busy",  32'(busy),       32'h0);

        arst_n = 1'b1;
        drive(1'b1, 40);

        push_vec(8'h55, 1'b1, 1'b0, 40, 8'h55, 1'b0);
        push_vec(8'hA3, 1'b0, 1'b0, 80, 8'hA3, 1'b1);
        push_vec(8'h11, 1'b1, 1'b0, 40, 8'h11, 1'b0);
        push_vec(8'h07, 1'b1, 1'b0, 40, 8'h07, 1'b0);
        push_vec(8'h07, 1'b1, 1'b1, 40, 8'h07, 1'b0);
        push_vec(8'h80, 1'b0, 1'b1, 80, 8'h80, 1'b1);
        push_vec(8'h01, 1'b1, 1'b1, 40, 8'h01, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].par, vecs[i].gap);
            expect_obs($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_ferr, vecs[i].exp_perr);
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
        end

        for (int i = 0; i < 20; i++) begin
            rd = DB'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            rp = 1'($urandom_range(0, 1));
            rg = rs ? $urandom_range(0, 40) : $urandom_range(70, 100);
            send_frame(rd, rs, rp, rg);
            expect_obs($sformatf("rnd%0d", i), rd, ~rs, model_perr(rd, rp));
        end
        drive(1'b1, 80);

        held = rx_data;
        drive(1'b0, 4 * TICK_DIV);
        drive(1'b1, 100);
        chk("glitch_novalid", 32'(obs_q.size()), 32'h0);
        chk("glitch_busy",    32'(busy),         32'h0);
        chk("glitch_held",    32'(rx_data),      32'(held));

        send_frame(8'h00, 1'b1, 1'b0, 0);
        send_frame(8'hFF, 1'b1, 1'b0, 40);
        expect_obs("b2b_first",  8'h00, 1'b0, model_perr(8'h00, 1'b0));
        expect_obs("b2b_second", 8'hFF, 1'b0, model_perr(8'hFF, 1'b0));

        drive(1'b0, BIT_CLK);
        for (int i = 0; i < 3; i++) drive(held[0] ^ held[0] ^ (8'h3C >> i) & 1'b1, BIT_CLK);
        drive(1'b1, 30);
        arst_n = 1'b0;
        rx     = 1'b1;
        repeat (10) @(negedge clk);
        arst_n = 1'b1;
        drive(1'b1, 100);
        chk("rst_novalid", 32'(obs_q.size()), 32'h0);
        chk("rst_data",    32'(rx_data),      32'h0);
        chk("rst_ferr",    32'(frame_err),    32'h0);
        chk("rst_perr",    32'(parity_err),   32'h0);
        chk("rst_busy",    32'(busy),         32'h0);

        send_frame(8'h3C, 1'b1, 1'b0, 40);
        expect_obs("after_rst", 8'h3C, 1'b0, model_perr(8'h3C, 1'b0));

        drive(1'b1, 50);
        chk("no_consecutive_valid", 32'(consec_cnt),   32'h0);
        chk("no_extra_valid",       32'(obs_q.size()), 32'h0);
        chk("valid_total",          32'(valid_total),  32'(vecs.size() + 20 + 3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
